gf180mcu_fd_sc_mcu7t5v0__swseq: RTL and testbench

Synchronous power-switch sequencer for a switchable VDD island built from the library's rail and tap cells.
- The fill/tie cells passively hold the rails. This block actively drives the rails:
  - turns on SEGS header-switch segments one at a time, to limit inrush current;
  - waits for a rail-good acknowledge;
  - releases isolation, then releases the domain reset.
- Power-down runs the same steps in reverse.
- Sits in the always-on domain, next to the switched island.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__swseq.sv | 187 ++++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__swseq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__swseq.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__swseq.sv - power-switch sequencer for a switchable VDD island
// Optional ack timeout: define GF180MCU_SWSEQ_ACK_TIMEOUT_EN
module gf180mcu_fd_sc_mcu7t5v0__swseq #(
  parameter int SEGS     = 4,
  parameter int STEP_CYC = 8,
  parameter int ISO_CYC  = 4,
  parameter int TMO_CYC  = 1024
) (
  input  logic            CLK,
  input  logic            RST,
  inout  wire             VDD,
  inout  wire             VSS,
  input  logic            PWR_REQ,
  input  logic            PWR_ACK,
  output logic [SEGS-1:0] SW_EN,
  output logic            ISO_EN,
  output logic            DOM_RSTN,
  output logic            PWR_ON,
  output logic            ERR
);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_UP   = 3'd1,
    S_WAIT = 3'd2,
    S_ISO  = 3'd3,
    S_REL  = 3'd4,
    S_ON   = 3'd5,
    S_DOWN = 3'd6
  } state_t;

  localparam logic [15:0] STEP_LAST = 16'(STEP_CYC - 1);
  localparam logic [15:0] ISO_LAST  = 16'(ISO_CYC - 1);
  // ISO is entered one cycle after the ack is seen, so release comes one count earlier
  localparam logic [15:0] REL_AT    = (ISO_CYC >= 2) ? 16'(ISO_CYC - 2) : 16'd0;

  wire unused_rails = VDD ^ VSS;

  state_t          state, state_n;
  logic [15:0]     cnt, cnt_n, cnt_inc;
  logic            pre, pre_n;
  logic [SEGS-1:0] sw_n, sw_up, sw_dn;
  logic            iso_n, drst_n, on_n;
  logic            ack_m, ack_s;

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign sw_up   = (SW_EN << 1) | SEGS'(1);
  assign sw_dn   = SW_EN >> 1;

`ifdef GF180MCU_SWSEQ_ACK_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  logic err_q, err_n;
  assign ERR = err_q;
`else
  wire [15:0] unused_tmo = 16'(TMO_CYC);
  assign ERR = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt_inc;
    pre_n   = pre;
    sw_n    = SW_EN;
    iso_n   = ISO_EN;
    drst_n  = DOM_RSTN;
    on_n    = PWR_ON;
`ifdef GF180MCU_SWSEQ_ACK_TIMEOUT_EN
    err_n   = err_q;
`endif
    case (state)
      S_OFF: begin
        cnt_n = '0;
        pre_n = 1'b0;
        if (PWR_REQ) begin
          state_n = S_UP;
          sw_n    = SEGS'(1);
`ifdef GF180MCU_SWSEQ_ACK_TIMEOUT_EN
          err_n   = 1'b0;
`endif
        end
      end
      S_UP, S_WAIT, S_ISO: begin
        // isolation is still asserted here, so an abort goes straight to segment drops
        if (!PWR_REQ) begin
          state_n = S_DOWN;
          cnt_n   = '0;
          pre_n   = 1'b0;
        end else if (state == S_UP) begin
          if (&SW_EN) begin
            state_n = S_WAIT;
            cnt_n   = '0;
          end else if (cnt >= STEP_LAST) begin
            sw_n  = sw_up;
            cnt_n = '0;
          end
        end else if (state == S_WAIT) begin
          if (ack_s) begin
            state_n = S_ISO;
            cnt_n   = '0;
          end
`ifdef GF180MCU_SWSEQ_ACK_TIMEOUT_EN
          else if (cnt >= TMO_LAST) begin
            err_n   = 1'b1;
            state_n = S_DOWN;
            cnt_n   = '0;
            pre_n   = 1'b0;
          end
`else
          else begin
            cnt_n = cnt;
          end
`endif
        end else if (cnt >= REL_AT) begin
          iso_n   = 1'b0;
          state_n = S_REL;
        end
      end
      S_REL, S_ON: begin
        if (!PWR_REQ) begin
          state_n = S_DOWN;
          iso_n   = 1'b1;
          drst_n  = 1'b0;
          on_n    = 1'b0;
          cnt_n   = '0;
          pre_n   = 1'b1;
        end else if (state == S_REL) begin
          state_n = S_ON;
          drst_n  = 1'b1;
          on_n    = 1'b1;
        end
      end
      S_DOWN: begin
        if (SW_EN == '0) begin
          state_n = S_OFF;
        end else if ((pre && cnt >= ISO_LAST) || (!pre && cnt >= STEP_LAST)) begin
          sw_n  = sw_dn;
          cnt_n = '0;
          pre_n = 1'b0;
          if (sw_dn == '0) state_n = S_OFF;
        end
      end
      default: begin
        state_n = S_OFF;
        cnt_n   = '0;
        pre_n   = 1'b0;
        sw_n    = '0;
        iso_n   = 1'b1;
        drst_n  = 1'b0;
        on_n    = 1'b0;
`ifdef GF180MCU_SWSEQ_ACK_TIMEOUT_EN
        err_n   = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_OFF;
      cnt      <= '0;
      pre      <= 1'b0;
      SW_EN    <= '0;
      ISO_EN   <= 1'b1;
      DOM_RSTN <= 1'b0;
      PWR_ON   <= 1'b0;
      ack_m    <= 1'b0;
      ack_s    <= 1'b0;
`ifdef GF180MCU_SWSEQ_ACK_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pre      <= pre_n;
      SW_EN    <= sw_n;
      ISO_EN   <= iso_n;
      DOM_RSTN <= drst_n;
      PWR_ON   <= on_n;
      ack_m    <= PWR_ACK;
      ack_s    <= ack_m;
`ifdef GF180MCU_SWSEQ_ACK_TIMEOUT_EN
      err_q    <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__swseq.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__swseq.sv - scoreboard bench for the power-switch sequencer
module tb_gf180mcu_fd_sc_mcu7t5v0__swseq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b1;
  logic       ack = 1'b1;
  logic [3:0] sw_en;
  logic       iso_en, dom_rstn, pwr_on, err;
  wire        vdd, vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__swseq #(
    .SEGS(4), .STEP_CYC(8), .ISO_CYC(4), .TMO_CYC(16)
  ) dut (
    .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss),
    .PWR_REQ(req), .PWR_ACK(ack),
    .SW_EN(sw_en), .ISO_EN(iso_en), .DOM_RSTN(dom_rstn), .PWR_ON(pwr_on), .ERR(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output word: {SW_EN, ISO_EN, DOM_RSTN, PWR_ON, ERR}
  typedef struct {
    int         c;
    logic [7:0] v;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic [7:0] outv, last;
  assign outv = {sw_en, iso_en, dom_rstn, pwr_on, err};
  initial last = 'x;

  task automatic push(input int c, input logic [7:0] v);
    exp_t e;
    e.c = c;
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every change of the output word must match the next expected (cycle, value) pair.
  always @(negedge clk) begin
    if (outv !== last) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cycle=%0d got=%h", cyc, outv);
      end else begin
        e = exp_q.pop_front();
        if (e.v !== outv || e.c != cyc) begin
          errors++;
          $display("FAIL out_change got=%h@%0d expected=%h@%0d", outv, cyc, e.v, e.c);
        end
      end
      last = outv;
    end
  end

  int e1, d1, e2, a1, e3, d2, e4, d3, e5;

  initial begin
    // reset with request already high
    push(1, 8'h08);
    wait_until(2);
    rst = 1'b0;

    // power-up with ack tied high
    e1 = 3;
    push(e1, 8'h18); push(e1 + 8, 8'h38); push(e1 + 16, 8'h78); push(e1 + 24, 8'hF8);
    push(e1 + 29, 8'hF0); push(e1 + 30, 8'hF6);

    // power-down from ON
    wait_until(e1 + 40);
    req = 1'b0;
    d1 = e1 + 41;
    push(d1, 8'hF8); push(d1 + 4, 8'h78); push(d1 + 12, 8'h38); push(d1 + 20, 8'h18);
    push(d1 + 28, 8'h08);

    // abort mid-ramp at 0011
    wait_until(d1 + 32);
    req = 1'b1;
    e2 = d1 + 33;
    push(e2, 8'h18); push(e2 + 8, 8'h38);
    wait_until(e2 + 10);
    req = 1'b0;
    a1 = e2 + 11;
    push(a1 + 8, 8'h18); push(a1 + 16, 8'h08);

    // full power-up, then a request raised during ramp-down
    wait_until(a1 + 20);
    req = 1'b1;
    e3 = a1 + 21;
    push(e3, 8'h18); push(e3 + 8, 8'h38); push(e3 + 16, 8'h78); push(e3 + 24, 8'hF8);
    push(e3 + 29, 8'hF0); push(e3 + 30, 8'hF6);
    wait_until(e3 + 35);
    req = 1'b0;
    d2 = e3 + 36;
    push(d2, 8'hF8); push(d2 + 4, 8'h78);
    wait_until(d2 + 6);
    req = 1'b1;
    push(d2 + 12, 8'h38); push(d2 + 20, 8'h18); push(d2 + 28, 8'h08);
    e4 = d2 + 29;
    push(e4, 8'h18); push(e4 + 8, 8'h38); push(e4 + 16, 8'h78); push(e4 + 24, 8'hF8);
    push(e4 + 29, 8'hF0); push(e4 + 30, 8'hF6);

    // power down, drop ack, request again: ramp reaches WAIT with no ack
    wait_until(e4 + 65);
    req = 1'b0;
    d3 = e4 + 66;
    push(d3, 8'hF8); push(d3 + 4, 8'h78); push(d3 + 12, 8'h38); push(d3 + 20, 8'h18);
    push(d3 + 28, 8'h08);
    wait_until(d3 + 5);
    ack = 1'b0;
    wait_until(d3 + 32);
    req = 1'b1;
    e5 = d3 + 33;
    push(e5, 8'h18); push(e5 + 8, 8'h38); push(e5 + 16, 8'h78); push(e5 + 24, 8'hF8);
`ifdef GF180MCU_SWSEQ_ACK_TIMEOUT_EN
    // WAIT entered at e5+25, timeout 16 cycles later, abort ramp-down, re-accept clears ERR
    push(e5 + 41, 8'hF9); push(e5 + 49, 8'h79); push(e5 + 57, 8'h39); push(e5 + 65, 8'h19);
    push(e5 + 73, 8'h09); push(e5 + 74, 8'h18);
    wait_until(e5 + 74);
    req = 1'b0;
    push(e5 + 83, 8'h08);
    wait_until(e5 + 100);
`else
    // no timeout: segments stay fully on while waiting for the ack
    wait_until(e5 + 150);
`endif

    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_change got=none expected=%h@%0d", e.v, e.c);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
